// File: rtl/sal_bank_ctrl.sv
// Per-bank DDR2 controller: one-entry request buffer, open-page row tracking,
// and per-bank ACT/RD/WR/PRE timing enforcement toward the command scheduler.
module sal_bank_ctrl #(
    parameter int RA_WIDTH  = 14,
    parameter int CA_WIDTH  = 10,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 4,
    parameter int T_RCD     = 4,
    parameter int T_RAS     = 12,
    parameter int T_RP      = 4,
    parameter int T_CCD     = 2,
    parameter int T_RTP     = 2,
    parameter int T_WR      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ID_WIDTH-1:0]  req_id,
    input  logic [RA_WIDTH-1:0]  req_ra,
    input  logic [CA_WIDTH-1:0]  req_ca,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 req_wr,
    output logic                 cmd_valid,
    output logic [1:0]           cmd_type,
    output logic [RA_WIDTH-1:0]  cmd_ra,
    output logic [CA_WIDTH-1:0]  cmd_ca,
    output logic [ID_WIDTH-1:0]  cmd_id,
    output logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 cmd_gnt,
    input  logic                 ref_req,
    output logic                 ref_ready
);

    localparam int T_M0  = (T_RCD > T_RAS) ? T_RCD : T_RAS;
    localparam int T_M1  = (T_RP  > T_CCD) ? T_RP  : T_CCD;
    localparam int T_M2  = (T_RTP > T_WR)  ? T_RTP : T_WR;
    localparam int T_M3  = (T_M0  > T_M1)  ? T_M0  : T_M1;
    localparam int T_MAX = (T_M3  > T_M2)  ? T_M3  : T_M2;
    // Counters only ever hold T-1, so $clog2(T_MAX) bits suffice.
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] RCD_L = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RAS_L = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] RP_L  = CNT_W'(T_RP  - 1);
    localparam logic [CNT_W-1:0] CCD_L = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] RTP_L = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] WR_L  = CNT_W'(T_WR  - 1);

    typedef enum logic [1:0] {CMD_ACT = 2'd0, CMD_RD = 2'd1, CMD_WR = 2'd2, CMD_PRE = 2'd3} cmd_t;
    typedef enum logic {ST_CLOSED = 1'b0, ST_OPEN = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t                 state, state_nxt;
    cmd_t                   cmd_type_c;
    logic                   cmd_vld_c, ref_rdy_c, issue, hit;
    logic                   buf_valid, buf_wr;
    logic [ID_WIDTH-1:0]    buf_id;
    logic [RA_WIDTH-1:0]    buf_ra, open_row;
    logic [CA_WIDTH-1:0]    buf_ca;
    logic [LEN_WIDTH-1:0]   buf_len;
    logic [CNT_W-1:0]       act_cnt, col_cnt, pre_cnt;
    logic                   accept;

    assign hit    = buf_valid && (buf_ra == open_row);
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLOSED;
        else     state <= state_nxt;
    end

    // Command selection; a row hit outranks a pending refresh.
    always_comb begin
        state_nxt  = state;
        cmd_vld_c  = 1'b0;
        cmd_type_c = CMD_ACT;
        ref_rdy_c  = 1'b0;
        issue      = 1'b0;
        case (state)
            ST_CLOSED: begin
                cmd_type_c = CMD_ACT;
                cmd_vld_c  = buf_valid && !ref_req && (act_cnt == '0);
                ref_rdy_c  = (act_cnt == '0);
            end
            ST_OPEN: begin
                if (hit) begin
                    cmd_type_c = buf_wr ? CMD_WR : CMD_RD;
                    cmd_vld_c  = (col_cnt == '0);
                end else if (buf_valid || ref_req) begin
                    cmd_type_c = CMD_PRE;
                    cmd_vld_c  = (pre_cnt == '0);
                end
            end
            default: state_nxt = ST_CLOSED;
        endcase
        if (rst) begin
            cmd_vld_c = 1'b0;
            ref_rdy_c = 1'b0;
        end
        issue = cmd_vld_c && cmd_gnt;
        if (issue && cmd_type_c == CMD_ACT) state_nxt = ST_OPEN;
        if (issue && cmd_type_c == CMD_PRE) state_nxt = ST_CLOSED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            act_cnt   <= '0;
            col_cnt   <= '0;
            pre_cnt   <= '0;
        end else begin
            act_cnt <= dec_sat(act_cnt);
            col_cnt <= dec_sat(col_cnt);
            pre_cnt <= dec_sat(pre_cnt);
            if (accept) buf_valid <= 1'b1;
            if (issue) begin
                case (cmd_type_c)
                    CMD_ACT: begin
                        col_cnt <= RCD_L;
                        pre_cnt <= RAS_L;
                    end
                    CMD_RD: begin
                        col_cnt   <= CCD_L;
                        pre_cnt   <= max_cnt(dec_sat(pre_cnt), RTP_L);
                        buf_valid <= 1'b0;
                    end
                    CMD_WR: begin
                        col_cnt   <= CCD_L;
                        pre_cnt   <= max_cnt(dec_sat(pre_cnt), WR_L);
                        buf_valid <= 1'b0;
                    end
                    default: act_cnt <= RP_L;
                endcase
            end
        end
    end

    // Request payload and open row carry no reset; their validity is tracked by control state.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_id  <= req_id;
            buf_ra  <= req_ra;
            buf_ca  <= req_ca;
            buf_len <= req_len;
            buf_wr  <= req_wr;
        end
        if (issue && cmd_type_c == CMD_ACT) open_row <= buf_ra;
    end

    assign req_ready = !buf_valid && !rst;
    assign cmd_valid = cmd_vld_c;
    assign cmd_type  = cmd_type_c;
    assign cmd_ra    = buf_ra;
    assign cmd_ca    = buf_ca;
    assign cmd_id    = buf_id;
    assign cmd_len   = buf_len;
    assign ref_ready = ref_rdy_c;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Directed bench for sal_bank_ctrl: a cycle table for miss/hit reads, then
// hand sequences for row conflict, backpressure, write recovery, refresh and reset.
module tb_sal_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_id = 4'h3;
    logic [13:0] req_ra = '0;
    logic [9:0]  req_ca = '0;
    logic [3:0]  req_len = 4'h7;
    logic        req_wr = 1'b0;
    logic        cmd_valid;
    logic [1:0]  cmd_type;
    logic [13:0] cmd_ra;
    logic [9:0]  cmd_ca;
    logic [3:0]  cmd_id;
    logic [3:0]  cmd_len;
    logic        cmd_gnt = 1'b1;
    logic        ref_req = 1'b0;
    logic        ref_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [1:0] ACT = 2'd0, RD = 2'd1, WR = 2'd2, PRE = 2'd3;

    always #5 clk = ~clk;

    sal_bank_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_ra(req_ra), .req_ca(req_ca), .req_len(req_len), .req_wr(req_wr),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ra(cmd_ra), .cmd_ca(cmd_ca),
        .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_gnt(cmd_gnt),
        .ref_req(ref_req), .ref_ready(ref_ready)
    );

    typedef struct {
        logic        rv;
        logic [13:0] ra;
        logic [9:0]  ca;
        logic        wr;
        logic        ev;
        logic [1:0]  et;
        logic [13:0] eaddr;
        logic        erdy;
        logic        eref;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        cmd_gnt = 1'b1;
        ref_req = 1'b0;
        step();
        #1;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ref_ready", ref_ready, 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic send(input logic [13:0] ra, input logic [9:0] ca, input logic wr);
        int n = 0;
        #1;
        while (!req_ready && n < 60) begin
            step();
            #1;
            n++;
        end
        chk("send_ready", req_ready, 1);
        req_valid = 1'b1;
        req_ra = ra;
        req_ca = ca;
        req_wr = wr;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_issue(input logic [1:0] typ, input string nm, output int at, output logic [13:0] ra_o);
        int n = 0;
        at = -1;
        ra_o = '0;
        #1;
        while (!(cmd_valid && cmd_gnt) && n < 60) begin
            step();
            #1;
            n++;
        end
        if (cmd_valid && cmd_gnt) begin
            chk({nm, "_type"}, cmd_type, typ);
            at = cyc;
            ra_o = cmd_ra;
            step();
        end else begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_issue expected=issue", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t, a, w, p;
        logic [13:0] ra;

        // rv ra ca wr | ev et eaddr erdy eref
        tbl[0] = '{1'b1, 14'h12, 10'h40, 1'b0, 1'b0, ACT, 14'h0,  1'b1, 1'b1};
        tbl[1] = '{1'b0, 14'h0,  10'h0,  1'b0, 1'b1, ACT, 14'h12, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 14'h0,  10'h0,  1'b0, 1'b0, ACT, 14'h0,  1'b0, 1'b0};
        tbl[3] = '{1'b0, 14'h0,  10'h0,  1'b0, 1'b0, ACT, 14'h0,  1'b0, 1'b0};
        tbl[4] = '{1'b0, 14'h0,  10'h0,  1'b0, 1'b0, ACT, 14'h0,  1'b0, 1'b0};
        tbl[5] = '{1'b0, 14'h0,  10'h0,  1'b0, 1'b1, RD,  14'h40, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 14'h12, 10'h44, 1'b0, 1'b0, ACT, 14'h0,  1'b1, 1'b0};
        tbl[7] = '{1'b0, 14'h0,  10'h0,  1'b0, 1'b1, RD,  14'h44, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 14'h0,  10'h0,  1'b0, 1'b0, ACT, 14'h0,  1'b1, 1'b0};

        // Read miss then back-to-back row hit
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req_valid = tbl[i].rv;
            req_ra = tbl[i].ra;
            req_ca = tbl[i].ca;
            req_wr = tbl[i].wr;
            #1;
            chk($sformatf("vec%0d_cmd_valid", i), cmd_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_cmd_type", i), cmd_type, tbl[i].et);
                if (tbl[i].et == ACT) chk($sformatf("vec%0d_cmd_ra", i), cmd_ra, tbl[i].eaddr);
                else                  chk($sformatf("vec%0d_cmd_ca", i), cmd_ca, tbl[i].eaddr);
            end
            chk($sformatf("vec%0d_req_ready", i), req_ready, tbl[i].erdy);
            chk($sformatf("vec%0d_ref_ready", i), ref_ready, tbl[i].eref);
            step();
        end
        req_valid = 1'b0;

        // Row conflict: tRAS then tRP
        do_reset();
        send(14'h12, 10'h40, 1'b0);
        wait_issue(ACT, "conf_act", c, ra);
        chk("conf_act_ra", ra, 14'h12);
        wait_issue(RD, "conf_rd", t, ra);
        chk("conf_rd_at", t, c + 4);
        send(14'h13, 10'h41, 1'b0);
        wait_issue(PRE, "conf_pre", t, ra);
        chk("conf_pre_at", t, c + 12);
        wait_issue(ACT, "conf_act2", t, ra);
        chk("conf_act2_at", t, c + 16);
        chk("conf_act2_ra", ra, 14'h13);

        // Backpressure on a pending RD, then write recovery before PRE
        do_reset();
        send(14'h30, 10'h55, 1'b0);
        wait_issue(ACT, "bp_act", a, ra);
        cmd_gnt = 1'b0;
        begin
            int n = 0;
            #1;
            while (!cmd_valid && n < 20) begin
                step();
                #1;
                n++;
            end
        end
        chk("bp_rd_valid_at", cyc, a + 4);
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", cmd_valid, 1);
            chk("bp_type", cmd_type, RD);
            chk("bp_ca", cmd_ca, 10'h55);
            chk("bp_ready", req_ready, 0);
            step();
            #1;
        end
        cmd_gnt = 1'b1;
        wait_issue(RD, "bp_rd", t, ra);
        chk("bp_rd_at", t, a + 14);
        send(14'h30, 10'h60, 1'b1);
        wait_issue(WR, "wr_wr", w, ra);
        chk("wr_wr_at", w, a + 16);
        send(14'h31, 10'h61, 1'b0);
        wait_issue(PRE, "wr_pre", t, ra);
        chk("wr_pre_at", t, w + 5);

        // Refresh closes an idle open row; ref_ready after tRP
        do_reset();
        send(14'h40, 10'h10, 1'b0);
        wait_issue(ACT, "ref_act", a, ra);
        wait_issue(RD, "ref_rd", t, ra);
        ref_req = 1'b1;
        wait_issue(PRE, "ref_pre", p, ra);
        chk("ref_pre_at", p, a + 12);
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("ref_ready_p%0d", k), ref_ready, (k == 4));
            step();
        end
        send(14'h41, 10'h11, 1'b0);
        #1;
        chk("ref_blocks_act", cmd_valid, 0);
        chk("ref_ready_closed", ref_ready, 1);
        ref_req = 1'b0;
        cmd_gnt = 1'b0;
        #1;
        chk("act_pending_valid", cmd_valid, 1);
        chk("act_pending_type", cmd_type, ACT);
        step();
        ref_req = 1'b1;
        #1;
        chk("act_withdrawn", cmd_valid, 0);
        ref_req = 1'b0;
        cmd_gnt = 1'b1;
        wait_issue(ACT, "ref_act2", t, ra);
        chk("ref_act2_ra", ra, 14'h41);

        // Reset during ACT->RD wait
        do_reset();
        send(14'h50, 10'h20, 1'b0);
        wait_issue(ACT, "mid_act", a, ra);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_ref", ref_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_valid", cmd_valid, 0);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_ref", ref_ready, 1);
        send(14'h50, 10'h20, 1'b0);
        wait_issue(ACT, "post_rst_reopen", t, ra);
        chk("post_rst_reopen_ra", ra, 14'h50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
